// File: rtl/perm_sched_pkg.sv
// Shared sizing helpers and default parameters for the permutation network scheduler.
package perm_sched_pkg;

  localparam int unsigned DEF_SLICES      = 8;
  localparam int unsigned DEF_LOG2SLICES  = 3;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_NREQ        = 2;
  localparam int unsigned DEF_NET_LAT     = 0;
  localparam int unsigned DEF_OFIFO_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Requester id width, never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned nreq);
    return (clog2(nreq) < 1) ? 1 : clog2(nreq);
  endfunction

  function automatic int unsigned slice_bits(input int unsigned slices, input int unsigned data_w);
    return slices * data_w;
  endfunction

  function automatic int unsigned addr_bits(input int unsigned slices, input int unsigned log2slices);
    return slices * log2slices;
  endfunction

endpackage

// File: rtl/perm_res_fifo.sv
// Result FIFO: simultaneous push/pop (also when full), occupancy count, zero head when empty.
module perm_res_fifo
  import perm_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [W-1:0]             head,
  output logic [clog2(DEPTH):0]    count
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         pop_ok;

  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid  = (wr_q != rd_q);
  assign pop_ok = pop && valid;
  assign count  = wr_q - rd_q;
  assign head   = valid ? mem[rd_q[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push)   wr_q <= wr_q + (AW+1)'(1);
      if (pop_ok) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop_ok))
    else $error("perm_res_fifo overflow");

endmodule

// File: rtl/perm_data_sched.sv
// Round-robin, credit-gated issue of requester vectors into the permutation network,
// with tagged capture of the fixed-latency network output into a result FIFO.
module perm_data_sched
  import perm_sched_pkg::*;
#(
  parameter int unsigned SLICES      = DEF_SLICES,
  parameter int unsigned LOG2SLICES  = DEF_LOG2SLICES,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned NREQ        = DEF_NREQ,
  parameter int unsigned NET_LAT     = DEF_NET_LAT,
  parameter int unsigned OFIFO_DEPTH = DEF_OFIFO_DEPTH
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NREQ-1:0]                                 req_valid,
  output logic [NREQ-1:0]                                 req_ready,
  input  logic [NREQ*slice_bits(SLICES, DATA_W)-1:0]      req_data,
  input  logic [NREQ*addr_bits(SLICES, LOG2SLICES)-1:0]   req_addr,
  output logic [slice_bits(SLICES, DATA_W)-1:0]           t_data_dat,
  output logic [addr_bits(SLICES, LOG2SLICES)-1:0]        t_addr_dat,
  input  logic [slice_bits(SLICES, DATA_W)-1:0]           i_data_dat,
  output logic                                            res_valid,
  input  logic                                            res_ready,
  output logic [slice_bits(SLICES, DATA_W)-1:0]           res_data,
  output logic [id_w(NREQ)-1:0]                           res_id,
  output logic [clog2(NET_LAT+2)-1:0]                     inflight
);

  localparam int unsigned SB  = slice_bits(SLICES, DATA_W);
  localparam int unsigned AB  = addr_bits(SLICES, LOG2SLICES);
  localparam int unsigned IDW = id_w(NREQ);
  localparam int unsigned IFW = clog2(NET_LAT+2);
  localparam int unsigned CW  = clog2(OFIFO_DEPTH) + 1;

  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    gid;
  logic [IDW-1:0]    ptr_next;
  logic [IDW-1:0]    idx;
  logic [IDW:0]      scan;
  logic              hit;
  logic [NREQ-1:0]   grant;
  logic              credit_ok;
  logic              issue;
  logic [SB-1:0]     win_data;
  logic [AB-1:0]     win_addr;
  logic [CW-1:0]     fifo_count;
  logic              iss_vld_q;
  logic [IDW-1:0]    iss_id_q;
  logic              cap_vld;
  logic [IDW-1:0]    cap_id;
  logic [SB+IDW-1:0] fifo_head;

  // Credit looks only at registered occupancy, so a pop frees a slot one cycle later.
  assign credit_ok = (32'(fifo_count) + 32'(inflight)) < 32'(OFIFO_DEPTH);

  always_comb begin
    grant = '0;
    gid   = '0;
    scan  = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      idx = IDW'(scan);
      if (!hit && credit_ok && !reset && req_valid[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        gid        = idx;
      end
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign ptr_next  = (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);

  always_comb begin
    win_data = '0;
    win_addr = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        win_data = req_data[k*SB +: SB];
        win_addr = req_addr[k*AB +: AB];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      t_data_dat <= '0;
      t_addr_dat <= '0;
      iss_vld_q  <= 1'b0;
      iss_id_q   <= '0;
      inflight   <= '0;
    end else begin
      iss_vld_q <= issue;
      iss_id_q  <= gid;
      if (issue) begin
        ptr_q      <= ptr_next;
        t_data_dat <= win_data;
        t_addr_dat <= win_addr;
      end
      case ({issue, cap_vld})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Tag follows the vector through the network; the issue register is the first stage.
  if (NET_LAT == 0) begin : g_no_pipe
    assign cap_vld = iss_vld_q;
    assign cap_id  = iss_id_q;
  end else begin : g_pipe
    logic [NET_LAT-1:0] pipe_vld_q;
    logic [IDW-1:0]     pipe_id_q [NET_LAT];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pipe_vld_q <= '0;
        for (int unsigned s = 0; s < NET_LAT; s++) pipe_id_q[s] <= '0;
      end else begin
        pipe_vld_q[0] <= iss_vld_q;
        pipe_id_q[0]  <= iss_id_q;
        for (int unsigned s = 1; s < NET_LAT; s++) begin
          pipe_vld_q[s] <= pipe_vld_q[s-1];
          pipe_id_q[s]  <= pipe_id_q[s-1];
        end
      end
    end

    assign cap_vld = pipe_vld_q[NET_LAT-1];
    assign cap_id  = pipe_id_q[NET_LAT-1];
  end

  perm_res_fifo #(
    .DEPTH (OFIFO_DEPTH),
    .W     (SB + IDW)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_vld),
    .push_data ({cap_id, i_data_dat}),
    .pop       (res_valid && res_ready),
    .valid     (res_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign res_data = fifo_head[SB-1:0];
  assign res_id   = fifo_head[SB +: IDW];

endmodule
